riscv_fetch_unit: RTL and testbench
===================================

// Module: riscv_fetch_unit
// PURPOSE
//  Parametrised instruction-fetch front end for the next-generation RISC-V core; replaces the
//  single-cycle direct inst_i/inst_addr_o coupling. Issues pipelined requests to inst_mem with
//  variable (>=1 cycle) in-order response latency and buffers {pc,inst} in a prefetch FIFO.
//  Feeds decode through a valid/ready port. Handles branch/jump redirects, including
//  discarding stale in-flight responses.
// PARAMETERS
//  XLEN        32      data/instruction width
//  ADDR_W      32      instruction address width
//  FIFO_DEPTH  4       prefetch entries; power of 2, >=2
//  MAX_OUTST   2       max requests in flight to inst_mem, 1..FIFO_DEPTH
//  RESET_PC    32'h0   first fetch address after reset
// PORTS
//  clk             in   1       single clock, rising edge
//  rst             in   1       synchronous, active-high reset
//  inst_ce_o       out  1       request valid to inst_mem
//  inst_addr_o     out  ADDR_W  request address, word aligned
//  inst_req_rdy_i  in   1       inst_mem accepts request this cycle
//  inst_valid_i    in   1       response valid; responses return in request order
//  inst_i          in   XLEN    response instruction word
//  redirect_i      in   1       branch/jump taken; flush and refetch
//  redirect_pc_i   in   ADDR_W  new PC; bits[1:0] ignored (treated as 0)
//  valid_o         out  1       {pc_o,inst_o} valid to decode
//  ready_i         in   1       decode consumes entry when valid_o&&ready_i
//  pc_o            out  ADDR_W  PC of head instruction
//  inst_o          out  XLEN    head instruction
// BEHAVIOUR
//  - Reset, while rst=1 and in the next cycle's outputs: inst_ce_o=0, valid_o=0, pc_o=0,
//    inst_o=0. Internal state: fetch_pc=RESET_PC, resp_pc=RESET_PC, FIFO empty, outst=0,
//    discard=0. inst_ce_o may first assert in the first cycle after rst drops.
//  - Credit rule: inst_ce_o = !rst && !redirect_i && outst<MAX_OUTST
//    && (fifo_count+outst)<FIFO_DEPTH. Every in-flight request therefore owns a FIFO slot,
//    and the FIFO can never overflow.
//  - Request accepted when inst_ce_o&&inst_req_rdy_i: fetch_pc+=4 (mod 2^ADDR_W, wraps),
//    outst+=1. inst_addr_o=fetch_pc and holds stable while ce=1 and rdy=0.
//  - Response (inst_valid_i): outst-=1.
//    - If discard>0: discard-=1 and the word is dropped.
//    - Otherwise push {resp_pc,inst_i} and resp_pc+=4.
//    - Accept and response in the same cycle leave outst unchanged.
//  - Head output: valid_o = (fifo_count>0) && !redirect_i; pc_o/inst_o = FIFO head
//    (registered storage, no comb path from inst_i to inst_o).
//    Min latency: request accepted at T, response at T+1, valid_o at T+2.
//  - Pop on valid_o&&ready_i. Pop and push in the same cycle keep count; legal when full.
//  - Redirect, cycle R:
//    - FIFO emptied; any pop in cycle R is ignored.
//    - fetch_pc = resp_pc = {redirect_pc_i[ADDR_W-1:2],2'b00}.
//    - discard = outst_next, i.e. all requests still in flight after cycle R. A response
//      arriving in cycle R is dropped.
//    - ce=0 in cycle R; fetching resumes at R+1.
//    - Back-to-back redirects: the last one wins; discard is recomputed each time.
//  - Redirect with outst=0 and FIFO empty only reloads the PC.
//  - A response with outst=0 is a protocol error: it is ignored, and a simulation-only
//    assertion fires.
//  - rst asserted mid-operation aborts everything. Late responses to pre-reset requests are
//    a protocol error; inst_mem is reset together with this block.
// STRUCTURE
//  - riscv_pkg (shared): XLEN, ADDR_W defaults, INST_BYTES=4, RESET_PC default,
//    typedef fetch_entry_t {pc, inst}.
//  - Sub-module riscv_fetch_fifo: sync FIFO, DEPTH/WIDTH params, push/pop/flush,
//    count output, registered head.
//  - Top level holds fetch_pc, resp_pc, the outst and discard counters, and the credit logic.
// TESTING
//  1. Reset release, mem always rdy, 1-cycle latency, ready_i=1 -> addresses 0,4,8...;
//     valid_o from cycle 2; pc_o/inst_o stream with no bubbles.
//  2. ready_i=0, DEPTH=4 -> exactly 4 requests issued and ce drops. ready_i=1 resumes;
//     no entry lost or duplicated.
//  3. 3-cycle latency, MAX_OUTST=2 -> never more than 2 outstanding; throughput 2 per
//     4 cycles; pc_o matches inst.
//  4. Redirect to 0x100 with 2 outstanding -> both stale responses dropped; next valid_o
//     shows pc_o=0x100; FIFO flushed in cycle R.
//  5. Redirect to 0x203 on the same cycle as a response and as a pop -> fetch resumes at
//     0x200; the response is dropped; no pop takes effect.
//  6. fetch_pc near 0xFFFFFFFC -> wraps to 0x0; rst pulse mid-stream -> all outputs 0,
//     refetch from RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: default widths, reset PC
// and the fetch-entry bundle passed from fetch to decode.
package riscv_pkg;

    localparam int XLEN_DEF = 32;
    localparam int ADDR_W_DEF = 32;
    localparam int INST_BYTES = 4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [XLEN_DEF-1:0]   inst;
    } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Prefetch FIFO: synchronous, power-of-2 depth, flushable,
// head read straight from registered storage.
module riscv_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         data,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] C_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] P_ONE = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // cleared so the head reads 0 out of reset
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data;
                wr_ptr      <= wr_ptr + P_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + P_ONE;
            end
            if (do_push && !do_pop) begin
                count <= count + C_ONE;
            end else if (!do_push && do_pop) begin
                count <= count - C_ONE;
            end
        end
    end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch front end: pipelined inst_mem requests,
// prefetch buffering and redirect with stale-response discard.
module riscv_fetch_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_OUTST = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              inst_ce_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    input  logic              inst_req_rdy_i,
    input  logic              inst_valid_i,
    input  logic [XLEN-1:0]   inst_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [XLEN-1:0]   inst_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int SW = CW + 1;
    localparam int EW = ADDR_W + XLEN;
    localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTST);
    localparam logic [OW-1:0] O_ONE = OW'(1);
    localparam logic [SW-1:0] DEPTH_S = SW'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INST_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [ADDR_W-1:0] target;
    logic [OW-1:0]     outst;
    logic [OW-1:0]     outst_next;
    logic [OW-1:0]     discard;
    logic [CW-1:0]     fifo_count;
    logic [EW-1:0]     head;
    logic              ce;
    logic              accept;
    logic              resp;
    logic              push;
    logic              pop;

    // each in-flight request reserves a FIFO slot
    assign ce = !rst && !redirect_i && (outst < OUT_MAX)
        && ((SW'(fifo_count) + SW'(outst)) < DEPTH_S);

    assign accept = ce && inst_req_rdy_i;
    assign resp   = inst_valid_i && (outst != '0);
    assign push   = resp && (discard == '0) && !redirect_i;
    assign target = redirect_pc_i & ALIGN;

    assign valid_o = !rst && (fifo_count != '0) && !redirect_i;
    assign pop     = valid_o && ready_i;

    assign inst_ce_o   = ce;
    assign inst_addr_o = fetch_pc;
    assign pc_o   = rst ? '0 : head[EW-1:XLEN];
    assign inst_o = rst ? '0 : head[XLEN-1:0];

    always_comb begin
        outst_next = outst;
        if (accept && !resp) begin
            outst_next = outst + O_ONE;
        end else if (!accept && resp) begin
            outst_next = outst - O_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            outst    <= '0;
            discard  <= '0;
        end else begin
            outst <= outst_next;
            if (redirect_i) begin
                fetch_pc <= target;
                resp_pc  <= target;
                discard  <= outst_next;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + STEP;
                end
                if (push) begin
                    resp_pc <= resp_pc + STEP;
                end
                if (resp && (discard != '0)) begin
                    discard <= discard - O_ONE;
                end
            end
        end
    end

    riscv_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_i),
        .push  (push),
        .pop   (pop),
        .data  ({resp_pc, inst_i}),
        .head  (head),
        .count (fifo_count)
    );

    a_resp_in_flight: assert property (
        @(posedge clk) disable iff (rst)
        inst_valid_i |-> (outst != '0)
    );

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Bench for riscv_fetch_unit: in-order memory model with
// variable latency and a PC scoreboard on the decode port.
module tb_riscv_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_ce_o;
    logic [31:0] inst_addr_o;
    logic        inst_req_rdy_i = 1'b1;
    logic        inst_valid_i = 1'b0;
    logic [31:0] inst_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [31:0] pc_o;
    logic [31:0] inst_o;

    riscv_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .inst_ce_o      (inst_ce_o),
        .inst_addr_o    (inst_addr_o),
        .inst_req_rdy_i (inst_req_rdy_i),
        .inst_valid_i   (inst_valid_i),
        .inst_i         (inst_i),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .pc_o           (pc_o),
        .inst_o         (inst_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_inst(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0013_0000;
    endfunction

    // memory model: in-order responses, lat cycles after accept
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    int          cyc = 0;
    int          lat = 1;
    bit          rdy_rand = 1'b0;

    always @(posedge clk) begin
        #2;
        cyc++;
        if (rst) begin
            mq_addr.delete();
            mq_due.delete();
            inst_valid_i   = 1'b0;
            inst_i         = '0;
            inst_req_rdy_i = 1'b1;
        end else begin
            inst_req_rdy_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
                inst_valid_i = 1'b1;
                inst_i       = mk_inst(mq_addr[0]);
            end else begin
                inst_valid_i = 1'b0;
                inst_i       = '0;
            end
        end
    end

    // scoreboard: expected PCs pushed on accept, popped on consume
    logic [31:0] expq[$];
    logic [31:0] exp_fetch = '0;
    logic [31:0] first_pc = '0;
    logic [31:0] e;
    bit          want_first = 1'b0;
    bit          prev_rst = 1'b0;
    bit          prev_redir = 1'b0;
    int          n_acc = 0;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ce", 32'(inst_ce_o), 0);
            chk("rst_valid", 32'(valid_o), 0);
            chk("rst_pc", pc_o, 0);
            chk("rst_inst", inst_o, 0);
            expq.delete();
            exp_fetch  = '0;
            prev_rst   = 1'b1;
            prev_redir = 1'b0;
        end else begin
            if (prev_rst) begin
                chk("post_rst_valid", 32'(valid_o), 0);
                chk("post_rst_pc", pc_o, 0);
                chk("post_rst_inst", inst_o, 0);
            end
            if (prev_redir) chk("flush", 32'(valid_o), 0);
            if (inst_ce_o) chk("credit", 32'(mq_addr.size() < 2), 1);
            if (inst_valid_i) begin
                if (mq_addr.size() == 0) begin
                    chk("resp_unexp", 0, 1);
                end else begin
                    void'(mq_addr.pop_front());
                    void'(mq_due.pop_front());
                end
            end
            if (inst_ce_o && inst_req_rdy_i) begin
                chk("addr", inst_addr_o, exp_fetch);
                mq_addr.push_back(inst_addr_o);
                mq_due.push_back(cyc + lat);
                expq.push_back(exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
                n_acc++;
            end
            if (redirect_i) begin
                chk("ce_redir", 32'(inst_ce_o), 0);
                chk("valid_redir", 32'(valid_o), 0);
                expq.delete();
                exp_fetch = redirect_pc_i & ~32'h3;
            end else if (valid_o && ready_i) begin
                if (expq.size() == 0) begin
                    chk("pop_unexp", 0, 1);
                end else begin
                    e = expq.pop_front();
                    chk("pc", pc_o, e);
                    chk("inst", inst_o, mk_inst(e));
                    if (want_first) begin
                        chk("first_pc", pc_o, first_pc);
                        want_first = 1'b0;
                    end
                end
            end
            prev_rst   = 1'b0;
            prev_redir = redirect_i;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] pc,
                            input logic [31:0] first);
        redirect_i    = 1'b1;
        redirect_pc_i = pc;
        first_pc      = first;
        want_first    = 1'b1;
        tick(1);
        redirect_i = 1'b0;
    endtask

    bit found;

    initial begin
        // 1: reset release, 1-cycle latency, streaming
        tick(3);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk(c < 2 ? "t1_lat" : "t1_stream",
                32'(valid_o), c < 2 ? 0 : 1);
        end
        tick(1);

        // 2: decode stalled, credit limits to FIFO depth
        rst = 1'b1;
        tick(2);
        ready_i = 1'b0;
        rst     = 1'b0;
        n_acc   = 0;
        tick(20);
        chk("t2_acc", n_acc, 4);
        chk("t2_ce", 32'(inst_ce_o), 0);
        ready_i = 1'b1;
        tick(10);

        // 3: 3-cycle latency, 2 per 4 cycles
        lat = 3;
        tick(10);
        n_acc = 0;
        tick(16);
        chk("t3_tput", n_acc, 8);

        // 4: redirect with two requests in flight
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            #1;
            if (mq_addr.size() == 2) found = 1'b1;
        end
        chk("t4_wait", 32'(found), 1);
        @(posedge clk);
        #1;
        redirect(32'h100, 32'h100);
        tick(15);
        chk("t4_seen", 32'(want_first), 0);

        // 5: misaligned redirect on a response and a pop
        lat = 1;
        tick(8);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h203;
        first_pc      = 32'h200;
        want_first    = 1'b1;
        @(negedge clk);
        chk("t5_resp_in_r", 32'(inst_valid_i), 1);
        tick(1);
        redirect_i = 1'b0;
        tick(10);
        chk("t5_seen", 32'(want_first), 0);

        // 6: address wrap, then reset mid-stream
        redirect(32'hFFFF_FFF6, 32'hFFFF_FFF4);
        tick(10);
        chk("t6_wrap_seen", 32'(want_first), 0);
        chk("t6_wrap_fetch", 32'(exp_fetch < 32'h100), 1);
        rst = 1'b1;
        tick(1);
        rst        = 1'b0;
        first_pc   = 32'h0;
        want_first = 1'b1;
        tick(10);
        chk("t6_refetch", 32'(want_first), 0);

        // random backpressure and redirects
        lat      = 2;
        rdy_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            ready_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) begin
                redirect_i    = 1'b1;
                redirect_pc_i = $urandom & 32'h0000_FFFF;
            end else begin
                redirect_i = 1'b0;
            end
            tick(1);
        end
        redirect_i = 1'b0;
        rdy_rand   = 1'b0;
        ready_i    = 1'b1;
        tick(10);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
